tdc_therm_gen: RTL and testbench

//   Stimulus-side counterpart of the TDC pop-count decoders: turns a requested ones-count

---
 rtl/tdc_therm_gen.sv | 143 ++++++++++++++
 tb/tb_tdc_therm_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_therm_gen.sv
// rtl/tdc_therm_gen.sv - thermometer-code word generator emulating a captured TDC delay line
//
// Purpose: turns a requested ones-count into an N-bit thermometer word x
// (x[k-1:0]=1, rest 0). Words are issued one at a time on request or as an
// automatic 0..N ramp. Each word is held for a programmable number of cycles.
//
// Ports:
//   clk          in   1       clock, all state on posedge
//   rst          in   1       asynchronous active-high reset
//   en           in   1       global enable; 0 freezes all state
//   cnt_valid    in   1       request a word with cnt ones
//   cnt_ready    out  1       request accepted when cnt_valid & cnt_ready
//   cnt          in   CW      requested ones count, saturates at N
//   hold_cycles  in   HOLD_W  cycles each word is held (0 acts as 1), sampled at start
//   sweep_start  in   1       pulse: start 0..N ramp
//   sweep_busy   out  1       high while ramp in progress
//   x            out  N       registered thermometer word
//   x_valid      out  1       one-cycle pulse when a new x is presented
//   x_cnt        out  CW      ones count of x, registered with x
module tdc_therm_gen #(
    parameter int N      = 64,
    parameter int HOLD_W = 8,
    localparam int CW    = $clog2(N) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cnt_valid,
    output logic              cnt_ready,
    input  logic [CW-1:0]     cnt,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic              sweep_start,
    output logic              sweep_busy,
    output logic [N-1:0]      x,
    output logic              x_valid,
    output logic [CW-1:0]     x_cnt
);

    localparam logic [CW-1:0] N_C = CW'(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        SWEEP = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [HOLD_W-1:0] ctr, ctr_n;
    // countdown reload value, captured once per request/sweep so that later
    // changes to hold_cycles cannot stretch or shorten the current operation
    logic [HOLD_W-1:0] rld, rld_n;
    logic [N-1:0]      x_n;
    logic [CW-1:0]     x_cnt_n;
    logic              x_valid_n;

    logic [CW-1:0]     cnt_sat;
    logic [HOLD_W-1:0] hold_ld;

    function automatic logic [N-1:0] therm(input logic [CW-1:0] k);
        logic [N-1:0] t;
        for (int i = 0; i < N; i++) begin
            t[i] = (CW'(i) < k);
        end
        return t;
    endfunction

    assign cnt_sat    = (cnt > N_C) ? N_C : cnt;
    assign hold_ld    = (hold_cycles == '0) ? '0 : hold_cycles - HOLD_W'(1);
    assign cnt_ready  = en & ~rst & (state == IDLE);
    assign sweep_busy = (state == SWEEP);

    always_comb begin
        state_n   = state;
        ctr_n     = ctr;
        rld_n     = rld;
        x_n       = x;
        x_cnt_n   = x_cnt;
        x_valid_n = 1'b0;
        unique case (state)
            IDLE: begin
                // a request takes priority; a simultaneous sweep_start is dropped
                if (cnt_valid && cnt_ready) begin
                    x_n       = therm(cnt_sat);
                    x_cnt_n   = cnt_sat;
                    x_valid_n = 1'b1;
                    ctr_n     = hold_ld;
                    rld_n     = hold_ld;
                    state_n   = HOLD;
                end else if (sweep_start && en) begin
                    x_n       = '0;
                    x_cnt_n   = '0;
                    x_valid_n = 1'b1;
                    ctr_n     = hold_ld;
                    rld_n     = hold_ld;
                    state_n   = SWEEP;
                end
            end
            HOLD: begin
                if (ctr != '0) begin
                    ctr_n = ctr - HOLD_W'(1);
                end else begin
                    state_n = IDLE;
                end
            end
            SWEEP: begin
                if (ctr != '0) begin
                    ctr_n = ctr - HOLD_W'(1);
                end else if (x_cnt < N_C) begin
                    // shifting a one in from the bottom keeps the word a thermometer code
                    x_n       = {x[N-2:0], 1'b1};
                    x_cnt_n   = x_cnt + CW'(1);
                    x_valid_n = 1'b1;
                    ctr_n     = rld;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ctr     <= '0;
            rld     <= '0;
            x       <= '0;
            x_cnt   <= '0;
            x_valid <= 1'b0;
        end else if (en) begin
            state   <= state_n;
            ctr     <= ctr_n;
            rld     <= rld_n;
            x       <= x_n;
            x_cnt   <= x_cnt_n;
            x_valid <= x_valid_n;
        end else begin
            // frozen: the current word stays put and is not re-announced on resume
            x_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tdc_therm_gen.sv
// tb/tb_tdc_therm_gen.sv - scoreboard bench for tdc_therm_gen
module tb_tdc_therm_gen;

    localparam int N      = 64;
    localparam int HOLD_W = 8;
    localparam int CW     = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              cnt_valid = 1'b0;
    logic              cnt_ready;
    logic [CW-1:0]     cnt = '0;
    logic [HOLD_W-1:0] hold_cycles = 8'd1;
    logic              sweep_start = 1'b0;
    logic              sweep_busy;
    logic [N-1:0]      x;
    logic              x_valid;
    logic [CW-1:0]     x_cnt;

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int busy_cnt = 0;
    int vcount = 0;
    int mon_e;
    logic [N-1:0] prev_x = '0;

    tdc_therm_gen #(.N(N), .HOLD_W(HOLD_W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cnt_valid(cnt_valid), .cnt_ready(cnt_ready), .cnt(cnt),
        .hold_cycles(hold_cycles), .sweep_start(sweep_start), .sweep_busy(sweep_busy),
        .x(x), .x_valid(x_valid), .x_cnt(x_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] tm(input int k);
        logic [N-1:0] t;
        if (k >= N) t = '1;
        else        t = (64'd1 << k) - 64'd1;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: pops one expectation per x_valid pulse, checks invariants every cycle
    always @(negedge clk) begin
        if (rst) begin
            prev_x = x;
        end else begin
            if (sweep_busy) busy_cnt++;
            if (x_valid) begin
                vcount++;
                if (exp_q.size() == 0) begin
                    check("x_valid_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("x_cnt", 64'(x_cnt), 64'(mon_e));
                    check("x_word", x, tm(mon_e));
                end
            end else begin
                check("x_changed_without_valid", x, prev_x);
            end
            check("x_is_therm", x, tm(int'(x_cnt)));
            prev_x = x;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!cnt_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!cnt_ready) check("wait_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(cnt_ready && !sweep_busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!(cnt_ready && !sweep_busy)) check("wait_idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_xcnt(input int v);
        int n = 0;
        @(negedge clk);
        while (int'(x_cnt) != v && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (int'(x_cnt) != v) check("wait_xcnt_timeout", 64'(x_cnt), 64'(v));
    endtask

    task automatic req(input int c, input int h, input int e);
        wait_ready();
        cnt         = CW'(c);
        hold_cycles = HOLD_W'(h);
        cnt_valid   = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1 cnt_valid = 1'b0;
    endtask

    task automatic sweep(input int h);
        wait_ready();
        hold_cycles = HOLD_W'(h);
        sweep_start = 1'b1;
        for (int k = 0; k <= N; k++) exp_q.push_back(k);
        @(posedge clk);
        #1 sweep_start = 1'b0;
    endtask

    initial begin
        int n;
        // reset state
        #12;
        check("rst_x", x, 64'd0);
        check("rst_x_cnt", 64'(x_cnt), 64'd0);
        check("rst_x_valid", 64'(x_valid), 64'd0);
        check("rst_busy", 64'(sweep_busy), 64'd0);
        en = 1'b1;
        #1 check("rst_cnt_ready", 64'(cnt_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 64'(cnt_ready), 64'd1);

        // single words, H=1, including saturation
        req(0, 1, 0);
        req(64, 1, 64);
        check("x_all_ones", x, 64'hFFFF_FFFF_FFFF_FFFF);
        req(70, 1, 64);
        check("x_sat", x, 64'hFFFF_FFFF_FFFF_FFFF);
        req(1, 1, 1);
        check("x_one", x, 64'h1);
        wait_idle();

        // H=3 back-to-back: ready low for exactly 3 cycles of HOLD
        req(5, 3, 5);
        check("x_5", x, 64'h1F);
        n = 0;
        @(negedge clk);
        while (!cnt_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("hold_ready_low_cycles", 64'(n), 64'd3);
        check("x_5_held", x, 64'h1F);
        req(9, 3, 9);
        check("x_9", x, 64'h1FF);
        wait_idle();

        // full ramp, H=0 treated as 1
        busy_cnt = 0;
        vcount   = 0;
        sweep(0);
        wait_idle();
        check("sweep_busy_cycles", 64'(busy_cnt), 64'd65);
        check("sweep_valid_pulses", 64'(vcount), 64'd65);
        check("sweep_end_x", x, 64'hFFFF_FFFF_FFFF_FFFF);

        // enable freeze mid-ramp
        sweep(1);
        wait_xcnt(20);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("frozen_x_cnt", 64'(x_cnt), 64'd20);
            check("frozen_x_valid", 64'(x_valid), 64'd0);
        end
        check("frozen_busy", 64'(sweep_busy), 64'd1);
        check("frozen_ready", 64'(cnt_ready), 64'd0);
        en = 1'b1;
        @(posedge clk);
        #1;
        check("resume_x_cnt", 64'(x_cnt), 64'd21);
        check("resume_x_valid", 64'(x_valid), 64'd1);
        wait_idle();

        // async reset mid-ramp
        sweep(1);
        wait_xcnt(10);
        @(posedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_x", x, 64'd0);
        check("midrst_x_cnt", 64'(x_cnt), 64'd0);
        check("midrst_busy", 64'(sweep_busy), 64'd0);
        check("midrst_x_valid", 64'(x_valid), 64'd0);
        check("midrst_ready", 64'(cnt_ready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // request and sweep_start together: request wins
        @(negedge clk);
        cnt         = 7'd7;
        hold_cycles = 8'd1;
        cnt_valid   = 1'b1;
        sweep_start = 1'b1;
        exp_q.push_back(7);
        @(posedge clk);
        #1;
        cnt_valid   = 1'b0;
        sweep_start = 1'b0;
        check("both_x", x, 64'h7F);
        check("both_busy", 64'(sweep_busy), 64'd0);
        repeat (5) @(negedge clk);
        check("both_no_sweep", 64'(sweep_busy), 64'd0);
        check("both_idle_ready", 64'(cnt_ready), 64'd1);
        check("both_x_kept", x, 64'h7F);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
